// File: rtl/picoblaze_irq_pkg.sv
// rtl/picoblaze_irq_pkg.sv - shared constants and types for the PicoBlaze interrupt scheduler
package picoblaze_irq_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [7:0] OFS_STATUS = 8'd0;
  localparam logic [7:0] OFS_MASK   = 8'd1;
  localparam logic [7:0] OFS_PEND   = 8'd2;
  localparam logic [7:0] OFS_ACTIVE = 8'd3;
  localparam logic [7:0] OFS_OVR    = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_rr_arbiter.sv
// rtl/irq_rr_arbiter.sv - combinational round-robin winner select over four sources
module irq_rr_arbiter
  import picoblaze_irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last_grant,
  output logic               grant_valid,
  output logic [1:0]         grant_id
);

  logic [1:0] idx;

  // Walk from the farthest candidate back to last_grant+1 so the nearest requester overwrites.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 2'd0;
    idx         = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      idx = last_grant + 2'(i + 1);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/picoblaze_irq_scheduler.sv
// rtl/picoblaze_irq_scheduler.sv - round-robin interrupt scheduler with an I/O register window
module picoblaze_irq_scheduler #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] PORT_BASE = 8'h10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_req,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic [7:0]         out_port,
  input  logic               read_strobe,
  output logic [7:0]         rd_data
);

  import picoblaze_irq_pkg::*;

  state_t             state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overrun;
  logic [NUM_SRC-1:0] mask;
  logic [1:0]         active_id;
  logic [1:0]         last_grant;

  logic               grant_valid;
  logic [1:0]         grant_id;
  logic               wr_mask, wr_pend, wr_eoi, wr_ovr;
  logic [NUM_SRC-1:0] ack_clr, pend_clr, ovr_clr;
  logic [7:0]         rd_next;
  logic               unused_bits;

  assign unused_bits = ^{read_strobe, out_port[7:NUM_SRC]};

  assign wr_mask = write_strobe && (port_id == PORT_BASE + OFS_MASK);
  assign wr_pend = write_strobe && (port_id == PORT_BASE + OFS_PEND);
  assign wr_eoi  = write_strobe && (port_id == PORT_BASE + OFS_ACTIVE);
  assign wr_ovr  = write_strobe && (port_id == PORT_BASE + OFS_OVR);

  assign ack_clr  = (state == ST_REQ && interrupt_ack) ? (NUM_SRC'(1) << active_id) : '0;
  assign pend_clr = ack_clr | (wr_pend ? out_port[NUM_SRC-1:0] : '0);
  assign ovr_clr  = wr_ovr ? out_port[NUM_SRC-1:0] : '0;

  irq_rr_arbiter u_arb (
    .req         (pending & mask),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    rd_next = 8'h00;
    if (port_id == PORT_BASE + OFS_STATUS)
      rd_next = {state == ST_REQ, state == ST_SERVICE, 4'b0000, active_id};
    else if (port_id == PORT_BASE + OFS_MASK)
      rd_next = {{(8 - NUM_SRC){1'b0}}, mask};
    else if (port_id == PORT_BASE + OFS_PEND)
      rd_next = {{(8 - NUM_SRC){1'b0}}, pending};
    else if (port_id == PORT_BASE + OFS_ACTIVE)
      rd_next = {6'b000000, active_id};
    else if (port_id == PORT_BASE + OFS_OVR)
      rd_next = {{(8 - NUM_SRC){1'b0}}, overrun};
  end

  // New requests are OR-ed in after the clears so a simultaneous set is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
      overrun <= '0;
      mask    <= '0;
      rd_data <= 8'h00;
    end else begin
      pending <= (pending & ~pend_clr) | irq_req;
      overrun <= (overrun & ~ovr_clr) | (irq_req & pending);
      if (wr_mask)
        mask <= out_port[NUM_SRC-1:0];
      rd_data <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      interrupt  <= 1'b0;
      active_id  <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            active_id <= grant_id;
            interrupt <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (interrupt_ack) begin
            interrupt <= 1'b0;
            state     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (wr_eoi) begin
            last_grant <= active_id;
            state      <= ST_IDLE;
          end
        end
        default: begin
          interrupt <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picoblaze_irq_scheduler.sv
// tb/tb_picoblaze_irq_scheduler.sv - directed self-checking bench for picoblaze_irq_scheduler
module tb_picoblaze_irq_scheduler;

  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq_req;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] rd_data;

  int total = 0;
  int bad   = 0;

  picoblaze_irq_scheduler #(.NUM_SRC(4), .PORT_BASE(BASE)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .irq_req       (irq_req),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [7:0] d);
    port_id = BASE + ofs; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; out_port = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [7:0] exp);
    port_id = BASE + ofs; read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    check(tag, rd_data, exp);
  endtask

  task automatic pulse(input logic [3:0] v);
    irq_req = v;
    tick();
    irq_req = 4'h0;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (interrupt !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check(tag, {7'b0, interrupt}, 8'h01);
  endtask

  initial begin
    reset_n = 1'b0; irq_req = 4'h0; interrupt_ack = 1'b0;
    port_id = 8'h00; write_strobe = 1'b0; out_port = 8'h00; read_strobe = 1'b0;
    tick(); tick();
    reset_n = 1'b1;

    check("reset_irq", {7'b0, interrupt}, 8'h00);
    check("reset_rd", rd_data, 8'h00);
    rd_chk("reset_status", 8'd0, 8'h00);
    rd_chk("reset_mask", 8'd1, 8'h00);
    rd_chk("reset_pend", 8'd2, 8'h00);
    rd_chk("unmapped", 8'd5, 8'h00);

    // Latency: pulse at edge N, interrupt visible after edge N+1.
    wr(8'd1, 8'h04);
    pulse(4'b0100);
    check("lat_n1", {7'b0, interrupt}, 8'h00);
    tick();
    check("lat_n2", {7'b0, interrupt}, 8'h01);
    rd_chk("lat_active", 8'd3, 8'h02);
    rd_chk("lat_status_req", 8'd0, 8'h82);
    ack();
    check("ack_drop", {7'b0, interrupt}, 8'h00);
    rd_chk("svc_status", 8'd0, 8'h42);
    rd_chk("svc_pend", 8'd2, 8'h00);
    wr(8'd3, 8'hA5);
    rd_chk("eoi_status", 8'd0, 8'h02);

    // Round-robin from reset: grants 0,1,2,3.
    do_reset();
    wr(8'd1, 8'h0F);
    pulse(4'b1111);
    begin
      logic [7:0] pend_exp [4];
      pend_exp[0] = 8'h0F; pend_exp[1] = 8'h0E; pend_exp[2] = 8'h0C; pend_exp[3] = 8'h08;
      for (int k = 0; k < 4; k++) begin
        wait_irq($sformatf("rr_irq%0d", k));
        rd_chk($sformatf("rr_pend%0d", k), 8'd2, pend_exp[k]);
        rd_chk($sformatf("rr_id%0d", k), 8'd3, 8'(k));
        ack();
        wr(8'd3, 8'h00);
      end
    end
    rd_chk("rr_pend_end", 8'd2, 8'h00);
    tick();
    check("rr_idle", {7'b0, interrupt}, 8'h00);

    // Overrun on source 1 and its W1C.
    do_reset();
    pulse(4'b0010);
    pulse(4'b0010);
    rd_chk("ovr_set", 8'd4, 8'h02);
    rd_chk("ovr_pend", 8'd2, 8'h02);
    wr(8'd4, 8'h02);
    rd_chk("ovr_clr", 8'd4, 8'h00);
    wr(8'd2, 8'h02);
    rd_chk("pend_w1c", 8'd2, 8'h00);

    // New request on the active source in the ack cycle survives.
    do_reset();
    wr(8'd1, 8'h04);
    pulse(4'b0100);
    wait_irq("race_irq1");
    interrupt_ack = 1'b1; irq_req = 4'b0100;
    tick();
    interrupt_ack = 1'b0; irq_req = 4'h0;
    check("race_drop", {7'b0, interrupt}, 8'h00);
    rd_chk("race_pend", 8'd2, 8'h04);
    wr(8'd3, 8'h00);
    wait_irq("race_irq2");
    rd_chk("race_id", 8'd3, 8'h02);

    // Reset while in REQ.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_req_irq", {7'b0, interrupt}, 8'h00);
    rd_chk("rst_req_status", 8'd0, 8'h00);
    rd_chk("rst_req_pend", 8'd2, 8'h00);
    rd_chk("rst_req_ovr", 8'd4, 8'h00);

    // Masked request, stray ack, ignored write, then unmask.
    pulse(4'b0001);
    tick(); tick();
    check("mask_hold", {7'b0, interrupt}, 8'h00);
    ack();
    rd_chk("mask_pend", 8'd2, 8'h01);
    port_id = BASE + 8'd1; out_port = 8'h01; write_strobe = 1'b0;
    tick();
    port_id = BASE + 8'd6; out_port = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    rd_chk("mask_nowrite", 8'd1, 8'h00);
    check("mask_nowrite_irq", {7'b0, interrupt}, 8'h00);
    wr(8'd1, 8'h01);
    tick();
    check("unmask_irq", {7'b0, interrupt}, 8'h01);
    rd_chk("unmask_id", 8'd3, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picoblaze_irq_scheduler.md
PICOBLAZE_IRQ_SCHEDULER -- requirements
Module: picoblaze_irq_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of interrupt request sources (fixed at 4 in this revision).
REQ-002 SHALL have parameter PORT_BASE, default 8'h10, base port_id of the register window (base+0..base+4).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port irq_req, input, 4, one-cycle clock-enable event pulses, one per source.
REQ-006 SHALL have port interrupt, output, 1, registered interrupt line to the PicoBlaze.
REQ-007 SHALL have port interrupt_ack, input, 1, one-cycle acknowledge from the PicoBlaze.
REQ-008 SHALL have ports port_id (input, 8), write_strobe (input, 1), out_port (input, 8) and read_strobe (input, 1), the PicoBlaze I/O bus.
REQ-009 SHALL have port rd_data, output, 8, registered read data for the in_port multiplexer.

Function
REQ-010 SHALL set pending[i] on the clock after irq_req[i]=1, whatever the state.
REQ-011 SHALL set overrun[i] if irq_req[i]=1 while pending[i] is already 1; overrun is sticky.
REQ-012 SHALL implement a state machine IDLE -> REQ -> SERVICE -> IDLE.
REQ-013 IDLE: if (pending & mask) != 0, SHALL latch winner id into active_id, assert interrupt and enter REQ on the same edge.
REQ-014 SHALL pick the winner round-robin: search starts at last_grant+1 mod 4; last_grant resets to 3, so source 0 wins first.
REQ-015 REQ: interrupt held at 1 until interrupt_ack=1; then clear pending[active_id], drive interrupt to 0 and enter SERVICE on the next edge.
REQ-016 REQ: masking or clearing the active source SHALL NOT deassert interrupt or change active_id.
REQ-017 SERVICE: a write to base+3 (EOI) SHALL set last_grant=active_id and return to IDLE; out_port data is ignored.
REQ-018 interrupt_ack outside REQ SHALL be ignored.
REQ-019 Worst-case latency SHALL be 2 cycles: irq_req at edge N, pending at N+1, interrupt=1 at N+2, when in IDLE with the source unmasked.
REQ-020 Register map (offset: read / write):
- +0: status {in_req, in_service, 4'b0, active_id[1:0]} / no effect
- +1: mask[3:0] in bits 3:0 / load mask
- +2: pending / write-1-to-clear
- +3: active_id / EOI
- +4: overrun / write-1-to-clear
- Upper bits read as 0.
REQ-021 Writes SHALL take effect only when write_strobe=1 and port_id matches exactly.
REQ-022 rd_data SHALL be registered one cycle after port_id and SHALL be independent of read_strobe. Unmapped port_id reads 8'h00. Reads have no side effects.
REQ-023 Set SHALL win over clear in the same cycle, for both pending (vs ack-clear or W1C) and overrun (vs W1C); no event is lost.
REQ-024 EOI in the same cycle as a new request SHALL allow the request to compete in IDLE on the following cycle.

Reset
REQ-025 With reset_n=0 at a clock edge, SHALL set: state=IDLE, interrupt=0, pending=0, overrun=0, mask=4'h0, active_id=0, last_grant=3, rd_data=8'h00.
REQ-026 Reset SHALL be honoured in any state, including mid-REQ or mid-SERVICE; interrupt=0 after that edge and no pending event survives.

Structure
REQ-027 Package picoblaze_irq_pkg SHALL hold the state enum, NUM_SRC and the register offset constants (OFS_STATUS, OFS_MASK, OFS_PEND, OFS_ACTIVE, OFS_OVR).
REQ-028 Winner selection SHALL be a combinational sub-module irq_rr_arbiter (inputs req[3:0], last_grant[1:0]; outputs grant_valid, grant_id[1:0]).

Verification
REQ-029 Reset, mask=4'h4, pulse irq_req=4'b0100 -> interrupt=1 exactly 2 cycles later; read base+3 returns 8'h02.
REQ-030 mask=4'hF, irq_req=4'b1111 in one cycle, ack+EOI each time -> grants in order 0,1,2,3; pending reads 4'hF, 4'hE, 4'hC, 4'h8, then 4'h0.
REQ-031 Source 1 pulsed twice while pending -> overrun reads 8'h02; write 8'h02 to base+4 -> reads 8'h00.
REQ-032 Source 2 pulse in the same cycle as ack of active source 2 -> pending[2] stays 1; a second interrupt follows after EOI.
REQ-033 reset_n=0 for one cycle while in REQ -> interrupt=0, status=8'h00, pending=8'h00 on the next read.
REQ-034 mask=4'h0 with irq_req pulses -> interrupt stays 0 and pending is set; mask write of 4'h1 -> interrupt=1 within 1 cycle.
